// File: rtl/id_decode_pipe_pkg.sv
// Shared decode constants, types and the instruction decoder for id_decode_pipe.
// Build option: define ID_SHIFT_INST_EN to decode SLL/SRL/SRA as the Shift class.
package id_decode_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_MOVE  = 3'b011;

  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_AND  = 8'h24;
  localparam logic [7:0] ALUOP_OR   = 8'h25;
  localparam logic [7:0] ALUOP_XOR  = 8'h26;
  localparam logic [7:0] ALUOP_NOR  = 8'h27;
  localparam logic [7:0] ALUOP_ANDI = 8'h2C;
  localparam logic [7:0] ALUOP_ORI  = 8'h2D;
  localparam logic [7:0] ALUOP_XORI = 8'h2E;
  localparam logic [7:0] ALUOP_LUI  = 8'h2F;
  localparam logic [7:0] ALUOP_SLL  = 8'h7C;
  localparam logic [7:0] ALUOP_SRL  = 8'h02;
  localparam logic [7:0] ALUOP_SRA  = 8'h03;
  localparam logic [7:0] ALUOP_MFHI = 8'h10;
  localparam logic [7:0] ALUOP_MTHI = 8'h11;
  localparam logic [7:0] ALUOP_MFLO = 8'h12;
  localparam logic [7:0] ALUOP_MTLO = 8'h13;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } state_e;

  typedef logic [2:0] cnt_t;

  typedef struct packed {
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic        re1;
    logic        re2;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] imm1;
    logic [31:0] imm2;
  } dec_t;

  // imm1/imm2 are the operand values used when the matching read enable is low.
  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t d;
    d = '0;
    case (inst[31:26])
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.alusel = ALUSEL_LOGIC;
        d.aluop  = (inst[31:26] == OP_ANDI) ? ALUOP_ANDI :
                   (inst[31:26] == OP_ORI)  ? ALUOP_ORI  : ALUOP_XORI;
        d.re1    = 1'b1;
        d.imm2   = {16'h0000, inst[15:0]};
        d.wd     = inst[20:16];
        d.wreg   = 1'b1;
      end
      OP_LUI: begin
        d.alusel = ALUSEL_LOGIC;
        d.aluop  = ALUOP_LUI;
        d.imm2   = {inst[15:0], 16'h0000};
        d.wd     = inst[20:16];
        d.wreg   = 1'b1;
      end
      OP_SPECIAL: begin
        if (inst != 32'h0) begin
          case (inst[5:0])
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              d.alusel = ALUSEL_LOGIC;
              d.aluop  = {2'b00, inst[5:0]};
              d.re1    = 1'b1;
              d.re2    = 1'b1;
              d.wd     = inst[15:11];
              d.wreg   = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              d.alusel = ALUSEL_MOVE;
              d.aluop  = (inst[5:0] == FN_MFHI) ? ALUOP_MFHI : ALUOP_MFLO;
              d.wd     = inst[15:11];
              d.wreg   = 1'b1;
            end
            FN_MTHI, FN_MTLO: begin
              d.alusel = ALUSEL_MOVE;
              d.aluop  = (inst[5:0] == FN_MTHI) ? ALUOP_MTHI : ALUOP_MTLO;
              d.re1    = 1'b1;
            end
`ifdef ID_SHIFT_INST_EN
            FN_SLL, FN_SRL, FN_SRA: begin
              d.alusel = ALUSEL_SHIFT;
              d.aluop  = (inst[5:0] == FN_SLL) ? ALUOP_SLL :
                         (inst[5:0] == FN_SRL) ? ALUOP_SRL : ALUOP_SRA;
              d.re2    = 1'b1;
              d.imm1   = {27'h0, inst[10:6]};
              d.wd     = inst[15:11];
              d.wreg   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_decode_pipe_if.sv
// ID/EX output bundle of id_decode_pipe: the decode stage drives it, EX consumes it.
interface id_decode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              valid_o;
  logic [DATA_W-1:0] pc_o;
  logic [2:0]        alusel_o;
  logic [7:0]        aluop_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;

  modport master (output valid_o, pc_o, alusel_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o);
  modport slave  (input  valid_o, pc_o, alusel_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o);
endinterface

// File: rtl/id_decode_pipe_fwd_mux.sv
// Priority forwarding selector: the lowest-numbered (youngest) matching source wins,
// and register 0 always reads as zero.
module id_decode_pipe_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FWD_SRC = 2
) (
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         rf_data_i,
  input  logic [FWD_SRC-1:0]        fwd_wreg_i,
  input  logic [FWD_SRC*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_SRC*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]         data_o
);
  logic hit;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    data_o = rf_data_i;
    hit    = 1'b0;
    for (int i = 0; i < FWD_SRC; i++) begin
      if (!hit && fwd_wreg_i[i] && (fwd_wd_i[i*REG_AW +: REG_AW] == addr_i)) begin
        data_o = fwd_wdata_i[i*DATA_W +: DATA_W];
        hit    = 1'b1;
      end
    end
    if (addr_i == '0) data_o = '0;
  end
endmodule

// File: rtl/id_decode_pipe.sv
// MIPS decode stage for the logic and HI/LO-move group with operand forwarding,
// load-use bubble insertion and an internal ID/EX register. Option: ID_SHIFT_INST_EN.
module id_decode_pipe
  import id_decode_pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int FWD_SRC      = 2,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid_i,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [FWD_SRC-1:0]        fwd_wreg_i,
  input  logic [FWD_SRC*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_SRC*DATA_W-1:0] fwd_wdata_i,
  input  logic                      ex_is_load_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      stallreq_o,
  id_decode_pipe_if.master          ex_if
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [2:0]        alusel;
    logic [7:0]        aluop;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [REG_AW-1:0] wd;
    logic              wreg;
  } idex_t;

  dec_t              dec;
  logic [REG_AW-1:0] rs, rt, wd0;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;
  logic              hazard, stall_req, bubble;
  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  idex_t             idex_q, idex_d;

  assign dec         = decode_inst(inst_i);
  assign rs          = REG_AW'(inst_i[25:21]);
  assign rt          = REG_AW'(inst_i[20:16]);
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  id_decode_pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_SRC(FWD_SRC)) u_fwd1 (
    .addr_i(rs), .rf_data_i(reg1_data_i), .fwd_wreg_i(fwd_wreg_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(fwd1_data)
  );
  id_decode_pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_SRC(FWD_SRC)) u_fwd2 (
    .addr_i(rt), .rf_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .data_o(fwd2_data)
  );

  // Only a load in EX (source 0) can create a hazard, and only against an operand actually read.
  assign wd0    = fwd_wd_i[REG_AW-1:0];
  assign hazard = inst_valid_i & ex_is_load_i & fwd_wreg_i[0] & (wd0 != '0) &
                  ((dec.re1 & (wd0 == rs)) | (dec.re2 & (wd0 == rt)));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (!stall_i) begin
      case (state_q)
        ST_RUN: begin
          if (hazard && (LOAD_BUBBLES > 1)) begin
            state_d = ST_LU_STALL;
            cnt_d   = cnt_t'(LOAD_BUBBLES - 2);
          end
        end
        ST_LU_STALL: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      ST_RUN:      stall_req = hazard;
      ST_LU_STALL: stall_req = 1'b1;
    endcase
    bubble = stall_req | ~inst_valid_i;
  end

  assign stallreq_o = stall_req;

  always_comb begin
    // NOTE: defaulting to the held value first keeps every path assigned, so no latch forms.
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (!stall_i) begin
      if (bubble) begin
        idex_d = '0;
      end else begin
        idex_d.valid  = 1'b1;
        idex_d.pc     = pc_i;
        idex_d.alusel = dec.alusel;
        idex_d.aluop  = dec.aluop;
        idex_d.reg1   = dec.re1 ? fwd1_data : DATA_W'(dec.imm1);
        idex_d.reg2   = dec.re2 ? fwd2_data : DATA_W'(dec.imm2);
        idex_d.wd     = REG_AW'(dec.wd);
        idex_d.wreg   = dec.wreg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_if.valid_o  = idex_q.valid;
  assign ex_if.pc_o     = idex_q.pc;
  assign ex_if.alusel_o = idex_q.alusel;
  assign ex_if.aluop_o  = idex_q.aluop;
  assign ex_if.reg1_o   = idex_q.reg1;
  assign ex_if.reg2_o   = idex_q.reg2;
  assign ex_if.wd_o     = idex_q.wd;
  assign ex_if.wreg_o   = idex_q.wreg;

endmodule
